// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs, states and mux selects.
package multicycle_control_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2a;
  localparam logic [5:0] FN_SLTU    = 6'h2b;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [31:0] SYSCALL_EXIT = 32'd10;

  // R-type arithmetic functs handled by the ALU
  function automatic logic rtype_fn(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_ADDU) || (fn == FN_SUB) || (fn == FN_SUBU) ||
           (fn == FN_AND) || (fn == FN_OR)   || (fn == FN_SLT) || (fn == FN_SLTU);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB, FN_SUBU: return ALU_SUB;
      FN_AND:          return ALU_AND;
      FN_OR:           return ALU_OR;
      FN_SLT, FN_SLTU: return ALU_SLT;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Memory wait counter; flags a timeout on the last permitted stalled cycle (MEM_TIMEOUT=0 disables).
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ready,
  input  logic clear,
  output logic timeout_c
);

  localparam int unsigned TO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  logic [TO_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)                count <= '0;
    else if (clear || ready)  count <= '0;
    else if (req)             count <= count + TO_W'(1);
  end

  assign timeout_c = (MEM_TIMEOUT != 0) && req && !ready && (count == TO_W'(TO_LAST));

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS datapath; SYSCALL_EN makes SYSCALL legal ($v0==10 halts).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic [31:0]        vreg,
  output logic               mem_req,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               halt,
  output logic               illegal,
  output logic [2:0]         state_o
);

  state_t     state, state_next;
  logic [2:0] alu3;
  logic       timeout_c;
  logic       wait_req;

  logic [5:0] op, fn;
  logic is_special, is_rtype, is_jr, is_sys, is_imm;
  logic is_lw, is_sw, is_beq, is_bne, is_j, is_jal, legal;
  logic [2:0] imm_alu;

  assign op         = instr[31:26];
  assign fn         = instr[5:0];
  assign is_special = (op == OP_SPECIAL);
  assign is_rtype   = is_special && rtype_fn(fn);
  assign is_jr      = is_special && (fn == FN_JR);
  assign is_sys     = is_special && (fn == FN_SYSCALL);
  assign is_imm     = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ORI) || (op == OP_SLTIU);
  assign is_lw      = (op == OP_LW);
  assign is_sw      = (op == OP_SW);
  assign is_beq     = (op == OP_BEQ);
  assign is_bne     = (op == OP_BNE);
  assign is_j       = (op == OP_J);
  assign is_jal     = (op == OP_JAL);
  assign imm_alu    = (op == OP_ORI) ? ALU_OR : (op == OP_SLTIU) ? ALU_SLT : ALU_ADD;

`ifdef SYSCALL_EN
  assign legal = is_rtype || is_jr || is_sys || is_imm || is_lw || is_sw ||
                 is_beq || is_bne || is_j || is_jal;
`else
  assign legal = is_rtype || is_jr || is_imm || is_lw || is_sw ||
                 is_beq || is_bne || is_j || is_jal;
  logic unused_vreg;
  assign unused_vreg = ^{vreg, is_sys};
`endif

  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  assign wait_req = (state == S_FETCH) || (state == S_MEM);

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .req       (wait_req),
    .ready     (mem_ready),
    .clear     (state_next != state),
    .timeout_c (timeout_c)
  );

  // State register plus sticky status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      halt    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == S_HALT) halt    <= 1'b1;
      if (state_next == S_ERR)  illegal <= 1'b1;
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu3       = ALU_AND;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = M2R_ALUOUT;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu3      = ALU_ADD;
        if (timeout_c) begin
          state_next = S_ERR;
        end else if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu3      = ALU_ADD;
        if (!legal) begin
          state_next = S_ERR;
        end else if (is_j) begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          state_next = S_FETCH;
        end else if (is_jal) begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          reg_write  = 1'b1;
          reg_dst    = DST_RA;
          mem_to_reg = M2R_PC;
          state_next = S_FETCH;
        end else if (is_jr) begin
          pc_write   = 1'b1;
          pc_src     = PC_RS;
          state_next = S_FETCH;
`ifdef SYSCALL_EN
        end else if (is_sys) begin
          state_next = (vreg == SYSCALL_EXIT) ? S_HALT : S_FETCH;
`endif
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (is_rtype) begin
          alu3       = funct_alu(fn);
          state_next = S_WB;
        end else if (is_beq || is_bne) begin
          alu3       = ALU_SUB;
          pc_src     = PC_ALUOUT;
          pc_write   = zero ^ is_bne;
          state_next = S_FETCH;
        end else begin
          alu_src_b  = SRCB_IMM;
          alu3       = imm_alu;
          state_next = (is_lw || is_sw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (timeout_c)      state_next = S_ERR;
        else if (mem_ready) state_next = is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype ? DST_RD : DST_RT;
        mem_to_reg = is_lw ? M2R_MDR : M2R_ALUOUT;
        state_next = S_FETCH;
      end
      default: state_next = state;
    endcase
  end

  assign alu_op  = ALUOP_W'(alu3);
  assign state_o = state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Sequential successor to the single-cycle MIPS control decoder. It is a Moore FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over several clocks. It drives datapath enables per state, stalls on a memory ready handshake, and flags illegal opcodes. It sits between the instruction register and the shared multi-cycle datapath (single ALU, single memory port).

Parameters:
ALUOP_W, 3, width of alu_op; encodings AND=0, OR=1, ADD=2, SUB=6, SLT=7 in the low 3 bits, upper bits zero.
MEM_TIMEOUT, 15, max cycles waiting on mem_ready before ERR; 0 disables the timeout.
TO_W, 4, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
instr  in  32  instruction register contents; valid from DECODE onward
zero  in  1  ALU zero flag, sampled in EXEC of a branch
mem_ready  in  1  memory completes the current access this cycle
vreg  in  32  $v0 value (used only with SYSCALL_EN)
mem_req  out  1  memory access request
mem_read  out  1  read qualifier
mem_write  out  1  write qualifier
iord  out  1  0 = PC address, 1 = ALUOut address
ir_write  out  1  latch instruction register
pc_write  out  1  unconditional PC update
pc_src  out  2  0 = ALU, 1 = ALUOut (branch), 2 = jump target, 3 = rs (JR)
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2
alu_op  out  ALUOP_W  ALU operation
reg_write  out  1  register file write
reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (JAL)
halt  out  1  sticky; set by SYSCALL exit
illegal  out  1  sticky; set by unsupported opcode/funct or timeout
state_o  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6.
- Reset: state FETCH; halt=0, illegal=0; wait counter 0. Every other output is a combinational decode of state, so outputs match FETCH. Reset has priority in any state, including mid memory wait.
- FETCH:
  - mem_req=1, mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - On mem_ready: ir_write=1 and pc_write=1 (pc_src=0), then go to DECODE.
  - Otherwise stay in FETCH and hold all outputs.
- DECODE:
  - alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target precompute).
  - Unsupported opcode or SPECIAL funct: go to ERR and set illegal.
  - J: pc_write=1, pc_src=2, go to FETCH.
  - JAL: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2, go to FETCH.
  - JR: pc_write=1, pc_src=3, go to FETCH.
  - All other supported instructions go to EXEC.
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=0, alu_op from funct, go to WB.
  - ADDI/ADDIU/ORI/SLTIU/LW/SW: alu_src_b=2, alu_op ADD, OR, SLT or ADD as appropriate; LW/SW go to MEM, the rest go to WB.
  - BEQ/BNE: alu_op=SUB, pc_src=1. pc_write=1 iff (zero XOR is_bne). Go to FETCH.
- MEM:
  - mem_req=1, iord=1; mem_read=1 for LW, mem_write=1 for SW.
  - Wait for mem_ready. SW then goes to FETCH; LW goes to WB.
- WB:
  - reg_write=1 for one cycle.
  - reg_dst=1 for R-type, else 0; mem_to_reg=1 for LW, else 0.
  - Go to FETCH.
- Latency excluding memory waits: BEQ/BNE 3, J/JAL/JR 2, R-type/imm 4, SW 4, LW 5.
- Timeout:
  - The counter increments each cycle mem_req=1 and mem_ready=0, and clears on mem_ready or state change.
  - Reaching MEM_TIMEOUT (nonzero) goes to ERR and sets illegal; the pending access is dropped.
- HALT and ERR are absorbing: all enables are 0 and only reset exits.
- reg_write, pc_write, ir_write and mem_write are never asserted outside the cases listed above.

Optional Feature:
SYSCALL_EN:
- Defined: SPECIAL/SYSCALL is legal.
  - vreg==10: go to HALT and set halt.
  - Any other vreg value: no-op, return to FETCH after DECODE.
- Undefined: SYSCALL is illegal and goes to ERR.

Decomposition:
- Shared package/header (extends mips.h): opcode/funct codes, the state encoding, alu_op encodings, and the pc_src/alu_src_b/reg_dst/mem_to_reg select encodings.
- One sub-module, mc_wait_timer: the wait counter plus timeout compare.

Test Plan:
- ADD $3,$1,$2 with mem_ready tied high: states 0→1→2→4→0; reg_write=1 only in cycle 4, reg_dst=1, alu_op=2.
- LW with mem_ready low for 3 cycles in MEM: MEM is held 4 cycles with mem_req=1, iord=1; then WB with mem_to_reg=1; total 8 cycles.
- BNE with zero=0, then zero=1: pc_write=1 in EXEC for the first case, 0 for the second; both return to FETCH after 3 cycles.
- JAL: DECODE asserts pc_write, pc_src=2, reg_write, reg_dst=2, mem_to_reg=2; next state is FETCH.
- Opcode 6'b111111: ERR, illegal=1, and it holds for 20 cycles; reset returns to FETCH with illegal=0.
- mem_ready held low in FETCH (MEM_TIMEOUT=15): ERR after 15 cycles. Separately, reset asserted mid-wait: FETCH on the next cycle.
